// File: rtl/mwadd_pkg.sv
// mwadd_pkg: sequencer state encoding and counter-width helper shared by the multiword adder files
package mwadd_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  function automatic int cnt_w(input int words);
    return words > 1 ? $clog2(words) : 1;
  endfunction
endpackage

// File: rtl/multiword_add_sequencer_if.sv
// multiword_add_sequencer_if: operand/result valid-ready bundle (in_valid/in_ready/in_a/in_b/in_cin[/in_sub with MWADD_SUB_EN], out_valid/out_ready/out_sum/out_cout, busy); master=producer+consumer, slave=sequencer
interface multiword_add_sequencer_if #(parameter int WIDTH = 8, parameter int WORDS = 4);
  localparam int N = WIDTH * WORDS;
  logic in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
  logic [N-1:0] in_a, in_b, out_sum;
`ifdef MWADD_SUB_EN
  logic in_sub;
`endif
  modport master (
`ifdef MWADD_SUB_EN
    output in_sub,
`endif
    output in_valid, in_a, in_b, in_cin, out_ready,
    input in_ready, out_valid, out_sum, out_cout, busy
  );
  modport slave (
`ifdef MWADD_SUB_EN
    input in_sub,
`endif
    input in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );
endinterface

// File: rtl/mwadd_chunk_adder.sv
// mwadd_chunk_adder: combinational WIDTH-bit full-adder chain; A, B, Cin in; S, Cout out
module mwadd_chunk_adder #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);
  logic [WIDTH:0] c;
  assign c[0] = Cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign Cout = c[WIDTH];
endmodule

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: WIDTH*WORDS-bit add (subtract with MWADD_SUB_EN) one chunk per cycle on a shared adder; ports clk, rst_n, bus (slave side of multiword_add_sequencer_if)
module multiword_add_sequencer import mwadd_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst_n,
  multiword_add_sequencer_if.slave bus
);
  localparam int N  = WIDTH * WORDS;
  localparam int CW = cnt_w(WORDS);
  state_t state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, out_valid_q, busy_q;
  logic [WIDTH-1:0] s;
  logic c, last, accept, sub;
`ifdef MWADD_SUB_EN
  assign sub = bus.in_sub;
`else
  assign sub = 1'b0;
`endif
  mwadd_chunk_adder #(.WIDTH(WIDTH)) u_add (
    .A(a_q[cnt_q*WIDTH +: WIDTH]),
    .B(b_q[cnt_q*WIDTH +: WIDTH]),
    .Cin(carry_q),
    .S(s),
    .Cout(c)
  );
  assign last         = cnt_q == CW'(WORDS - 1);
  // S_DONE hands over to a new operand in the same cycle the result is taken
  assign bus.in_ready = state_q == S_IDLE || (state_q == S_DONE && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    if (accept) begin
      state_d = S_RUN;
      a_d     = bus.in_a;
      // subtraction is A + ~B + 1, so B is stored inverted and the carry forced
      b_d     = sub ? ~bus.in_b : bus.in_b;
      carry_d = sub | bus.in_cin;
      cnt_d   = '0;
      sum_d   = '0;
    end else if (state_q == S_RUN) begin
      sum_d[cnt_q*WIDTH +: WIDTH] = s;
      carry_d = c;
      cnt_d   = cnt_q + CW'(!last);
      state_d = last ? S_DONE : S_RUN;
    end else if (state_q == S_DONE && bus.out_ready) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      out_valid_q <= state_d == S_DONE;
      busy_q      <= state_d == S_RUN;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = carry_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: directed vectors with a scoreboard queue per instance (WORDS=4 and WORDS=1)
module tb_multiword_add_sequencer;
  typedef struct {logic [31:0] sum; logic cout; int acc;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int cyc = 0, total = 0, bad = 0;
  exp_t q[$], q1[$];
  logic pv = 1'b0, pv1 = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  multiword_add_sequencer_if #(.WIDTH(8), .WORDS(4)) bus();
  multiword_add_sequencer_if #(.WIDTH(8), .WORDS(1)) bus1();
  multiword_add_sequencer #(.WIDTH(8), .WORDS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  multiword_add_sequencer #(.WIDTH(8), .WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                      input logic [31:0] es, input logic ec, input bit push);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_cin = cin;
`ifdef MWADD_SUB_EN
    bus.in_sub = sub;
`endif
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    chk("accept", bus.in_ready, 1);
    if (push) q.push_back('{es, ec, cyc + 1});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int n = 0; n < 100 && (q.size() > 0 || q1.size() > 0); n++) @(posedge clk);
    chk("drain", q.size() + q1.size(), 0);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid) begin
      if (q.size() == 0) chk("unexpected_valid", bus.out_valid, 0);
      else begin
        if (!pv) chk("latency4", cyc - q[0].acc, 4);
        if (bus.out_ready) begin
          e = q.pop_front();
          chk("sum", bus.out_sum, e.sum);
          chk("cout", bus.out_cout, e.cout);
        end else begin
          chk("held_sum", bus.out_sum, q[0].sum);
          chk("held_in_ready", bus.in_ready, 0);
        end
      end
    end
    pv = bus.out_valid && !bus.out_ready;
  end
  always @(negedge clk) begin
    exp_t e;
    if (bus1.out_valid) begin
      if (q1.size() == 0) chk("unexpected_valid1", bus1.out_valid, 0);
      else begin
        if (!pv1) chk("latency1", cyc - q1[0].acc, 1);
        if (bus1.out_ready) begin
          e = q1.pop_front();
          chk("sum1", {24'b0, bus1.out_sum}, e.sum);
          chk("cout1", bus1.out_cout, e.cout);
        end
      end
    end
    pv1 = bus1.out_valid && !bus1.out_ready;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    {bus.in_valid, bus.in_a, bus.in_b, bus.in_cin} = '0;
    {bus1.in_valid, bus1.in_a, bus1.in_b, bus1.in_cin} = '0;
`ifdef MWADD_SUB_EN
    bus.in_sub = 1'b0;
    bus1.in_sub = 1'b0;
`endif
    bus.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_sum", bus.out_sum, 0);
    chk("rst_cout", bus.out_cout, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    chk("busy_run", bus.busy, 1);
    chk("in_ready_run", bus.in_ready, 0);
    drain();
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1);
    drain();
    bus.out_ready = 1'b0;
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1);
    for (int n = 0; n < 20 && !bus.out_valid; n++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_valid", bus.out_valid, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("bp_busy", bus.busy, 0);
    bus.out_ready = 1'b1;
    send(32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0, 1);
    chk("b2b_busy", bus.busy, 1);
    drain();
    send(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_sum", bus.out_sum, 0);
    chk("midrst_cout", bus.out_cout, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", bus.out_valid, 0);
    send(32'h5, 32'h5, 1'b0, 1'b0, 32'hA, 1'b0, 1);
    drain();
`ifdef MWADD_SUB_EN
    send(32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1);
    drain();
    send(32'h7, 32'h5, 1'b0, 1'b1, 32'h2, 1'b1, 1);
    drain();
`endif
    bus1.in_a = 8'hFF;
    bus1.in_b = 8'h01;
    bus1.in_cin = 1'b0;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    chk("w1_accept", bus1.in_ready, 1);
    q1.push_back('{32'h0, 1'b1, cyc + 1});
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    drain();
    bus1.in_a = 8'h12;
    bus1.in_b = 8'h34;
    bus1.in_cin = 1'b1;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    chk("w1_accept2", bus1.in_ready, 1);
    q1.push_back('{32'h47, 1'b0, cyc + 1});
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    drain();
    chk("queues_empty", q.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
